// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store, with data priority.
// Optional fetch starvation guard is compiled in with `define ARB_STARVE_GUARD_EN.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              ihit,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dhit,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   localparam logic [1:0] RS_ACCESS = 2'd2;

   state_t            state, state_n;
   logic              own_d;
   logic              lat_wen;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_store;
   logic              grant_d, grant_i;
   logic              fetch_pri;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;

   assign fetch_pri = iREN && (starve_cnt == 4'(STARVE_MAX));

   // Counts data grants that jumped a waiting fetch; any fetch grant resets it.
   always_ff @(posedge CLK) begin
      if (RST)
         starve_cnt <= '0;
      else if (grant_i)
         starve_cnt <= '0;
      else if (grant_d && iREN)
         starve_cnt <= starve_cnt + 4'd1;
   end
`else
   assign fetch_pri = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      grant_d = 1'b0;
      grant_i = 1'b0;
      case (state)
         IDLE: begin
            if (fetch_pri)
               grant_i = 1'b1;
            else if (dREN || dWEN)
               grant_d = 1'b1;
            else if (iREN)
               grant_i = 1'b1;
            if (grant_d || grant_i)
               state_n = BUSY;
         end
         // FREE/BUSY hold, ERROR keeps the same access on the port as a retry.
         BUSY:    if (ramstate == RS_ACCESS) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         own_d     <= 1'b0;
         lat_wen   <= 1'b0;
         lat_addr  <= '0;
         lat_store <= '0;
         iload     <= '0;
         dload     <= '0;
      end else begin
         if (grant_d) begin
            own_d     <= 1'b1;
            lat_wen   <= dWEN;
            lat_addr  <= daddr;
            lat_store <= dstore;
         end else if (grant_i) begin
            own_d    <= 1'b0;
            lat_wen  <= 1'b0;
            lat_addr <= iaddr;
         end
         if (state == BUSY && ramstate == RS_ACCESS) begin
            if (own_d)
               dload <= ramload;
            else
               iload <= ramload;
         end
      end
   end

   assign ihit     = (state == RESP) && !own_d;
   assign dhit     = (state == RESP) &&  own_d;
   assign ramREN   = (state == BUSY) && !lat_wen;
   assign ramWEN   = (state == BUSY) &&  lat_wen;
   assign ramaddr  = lat_addr;
   assign ramstore = lat_store;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vector table plus reset-abort and starvation sequences.
module tb_mem_arbiter;

   localparam logic [1:0] RF = 2'd0, RB = 2'd1, RA = 2'd2, RE = 2'd3;

   logic        CLK = 1'b0;
   logic        RST, iREN, dREN, dWEN, ihit, dhit, ramREN, ramWEN;
   logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   // ctl = {RST,iREN,dREN,dWEN}; ef = {ihit,dhit,ramREN,ramWEN} after the edge
   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] ia, da, ds;
      logic [1:0]  rs;
      logic [31:0] rl;
      logic [3:0]  ef;
      logic [31:0] ea, es, eil, edl;
   } vec_t;

   vec_t tv[23];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string nm, input logic [135:0] got, input logic [135:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [135:0] outs();
      return {ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, iload, dload};
   endfunction

   logic [7:0] got_g[6], exp_g[6];
   int         ng;
   logic       saw_hit;

   initial begin
      tv[0]  = '{4'b1110, 32'h40, 32'h20, 32'h0, RF, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0};
      tv[1]  = tv[0];
      tv[2]  = tv[0];
      tv[3]  = '{4'b0110, 32'h40, 32'h20, 32'h0, RF, 32'h0, 4'b0010, 32'h20, 32'h0, 32'h0, 32'h0};
      tv[4]  = '{4'b0110, 32'h40, 32'h20, 32'h0, RA, 32'h11111111, 4'b0100, 32'h20, 32'h0, 32'h0, 32'h11111111};
      tv[5]  = '{4'b0110, 32'h40, 32'h20, 32'h0, RF, 32'h0, 4'b0000, 32'h20, 32'h0, 32'h0, 32'h11111111};
      tv[6]  = '{4'b0100, 32'h40, 32'h20, 32'h0, RF, 32'h0, 4'b0010, 32'h40, 32'h0, 32'h0, 32'h11111111};
      tv[7]  = '{4'b0100, 32'h40, 32'h20, 32'h0, RB, 32'h0, 4'b0010, 32'h40, 32'h0, 32'h0, 32'h11111111};
      tv[8]  = tv[7];
      tv[9]  = '{4'b0100, 32'h40, 32'h20, 32'h0, RA, 32'hDEADBEEF, 4'b1000, 32'h40, 32'h0, 32'hDEADBEEF, 32'h11111111};
      tv[10] = '{4'b0100, 32'h40, 32'h20, 32'h0, RF, 32'h0, 4'b0000, 32'h40, 32'h0, 32'hDEADBEEF, 32'h11111111};
      tv[11] = '{4'b0101, 32'h44, 32'h80, 32'h12345678, RF, 32'h0, 4'b0001, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'h11111111};
      tv[12] = '{4'b0101, 32'h44, 32'h80, 32'h12345678, RA, 32'h11111111, 4'b0100, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'h11111111};
      tv[13] = '{4'b0101, 32'h44, 32'h80, 32'h12345678, RF, 32'h0, 4'b0000, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'h11111111};
      tv[14] = '{4'b0100, 32'h44, 32'h80, 32'h12345678, RF, 32'h0, 4'b0010, 32'h44, 32'h12345678, 32'hDEADBEEF, 32'h11111111};
      tv[15] = '{4'b0100, 32'h44, 32'h80, 32'h12345678, RA, 32'hCAFEF00D, 4'b1000, 32'h44, 32'h12345678, 32'hCAFEF00D, 32'h11111111};
      tv[16] = '{4'b0100, 32'h44, 32'h80, 32'h12345678, RF, 32'h0, 4'b0000, 32'h44, 32'h12345678, 32'hCAFEF00D, 32'h11111111};
      tv[17] = '{4'b0010, 32'h44, 32'h90, 32'h12345678, RF, 32'h0, 4'b0010, 32'h90, 32'h12345678, 32'hCAFEF00D, 32'h11111111};
      tv[18] = '{4'b0010, 32'h44, 32'h90, 32'h12345678, RB, 32'h0, 4'b0010, 32'h90, 32'h12345678, 32'hCAFEF00D, 32'h11111111};
      tv[19] = '{4'b0010, 32'h44, 32'h90, 32'h12345678, RE, 32'h0, 4'b0010, 32'h90, 32'h12345678, 32'hCAFEF00D, 32'h11111111};
      tv[20] = '{4'b0010, 32'h44, 32'h90, 32'h12345678, RA, 32'h55AA55AA, 4'b0100, 32'h90, 32'h12345678, 32'hCAFEF00D, 32'h55AA55AA};
      tv[21] = '{4'b0010, 32'h44, 32'h90, 32'h12345678, RF, 32'h0, 4'b0000, 32'h90, 32'h12345678, 32'hCAFEF00D, 32'h55AA55AA};
      tv[22] = '{4'b0000, 32'h44, 32'h90, 32'h12345678, RF, 32'h0, 4'b0000, 32'h90, 32'h12345678, 32'hCAFEF00D, 32'h55AA55AA};

      RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RF;
      step();

      for (int k = 0; k < 23; k++) begin
         {RST, iREN, dREN, dWEN} = tv[k].ctl;
         iaddr = tv[k].ia; daddr = tv[k].da; dstore = tv[k].ds;
         ramstate = tv[k].rs; ramload = tv[k].rl;
         step();
         check($sformatf("vec%0d", k), outs(),
               {tv[k].ef, tv[k].ea, tv[k].es, tv[k].eil, tv[k].edl});
      end

      // Reset while BUSY: access is dropped and never produces a hit.
      RST = 1'b1; step();
      RST = 1'b0; dREN = 1'b1; daddr = 32'hA0; ramstate = RB; step();
      check("abort_busy", {63'b0, ramREN, ramaddr}, {63'b0, 1'b1, 32'hA0});
      RST = 1'b1; step();
      check("abort_rst", {63'b0, ramREN, ramaddr}, {63'b0, 1'b0, 32'h0});
      RST = 1'b0; dREN = 1'b0; ramstate = RA; saw_hit = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         saw_hit = saw_hit | ihit | dhit | ramREN;
      end
      check("abort_nohit", {135'b0, saw_hit}, 136'b0);

      // Grant order under sustained fetch + data pressure, zero-wait RAM.
`ifdef ARB_STARVE_GUARD_EN
      exp_g = '{"D", "D", "I", "D", "D", "I"};
`else
      exp_g = '{"D", "D", "D", "D", "D", "D"};
`endif
      RST = 1'b1; step();
      RST = 1'b0; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200; ramstate = RA;
      ng = 0;
      for (int c = 0; c < 60 && ng < 6; c++) begin
         step();
         if (ihit) begin got_g[ng] = "I"; ng++; end
         else if (dhit) begin got_g[ng] = "D"; ng++; end
      end
      if (ng < 6) begin
         n_chk++; n_err++;
         $display("FAIL starve_timeout: got %0d grants expected 6", ng);
      end
      for (int g = 0; g < ng; g++)
         check($sformatf("grant%0d", g), {128'b0, got_g[g]}, {128'b0, exp_g[g]});
      iREN = 1'b0; dREN = 1'b0; step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
